seg_disp_arbiter: RTL and testbench
===================================

# seg_disp_arbiter

Shares the board's single multiplexed 8-digit 7-segment display among three function blocks: wall clock, countdown timer and stopwatch. Each function block posts a 6-digit BCD hh:mm:ss image plus a request. The arbiter grants exactly one owner under fixed priority, with a minimum-hold rule and frame-aligned switching. It scans the owner's digits onto `seg_com`/`seg_data` and replaces the per-module scan logic in the function blocks.

## Interface
- `SCAN_DIV`, default 1: clock cycles per digit slot.
- `HOLD`, default 1000: minimum ownership cycles before a higher-priority requester may preempt.
- `BLINK_HALF`, default 500: cycles per blink phase (on or off).
- `clk`, input, 1: 1 kHz system clock. One clock domain only.
- `rst`, input, 1: synchronous, active-high reset.
- `req`, input, 3: display requests. Bit 0 is clock, bit 1 is timer, bit 2 is stopwatch. Priority is 2 > 1 > 0.
- `digits0`, `digits1`, `digits2`, input, 24 each: BCD image per source. Bits [23:20] are h_ten, then h_one, m_ten, m_one, s_ten; bits [3:0] are s_one.
- `blink`, input, 3: per-source blink enable (setting-mode feedback).
- `grant`, output, 3: one-hot current owner, or 0 when idle.
- `seg_com`, output, 8: active-low digit select.
- `seg_data`, output, 8: active-high segments in the order {a,b,c,d,e,f,g,dp}.

## Operation
- Scan divider `div` counts 0..SCAN_DIV-1. `tick` is asserted when div == SCAN_DIV-1.
- `slot` (3 bits) increments on each `tick` and wraps 7→0.
- `frame_end` = tick && slot == 7.
- Slot to `seg_com` mapping:
  - slot 0 → 0111_1111
  - slot 1 → 1011_1111
  - slot 2 → 1101_1111
  - slot 3 → 1110_1111
  - slot 4 → 1111_0111
  - slot 5 → 1111_1011
  - slots 6 and 7 → 1111_1111, with `seg_data` = 00
- Slots 0..5 display owner digits [23:20] through [3:0], in order.
- Segment decode:
  - 0=FC, 1=60, 2=DA, 3=F2, 4=66
  - 5=B6, 6=BE, 7=E0, 8=FE, 9=F6
  - Nibble values 10..15 decode to 00 (blank).
- DP (bit 0) is forced to 1 on slots 1 and 3, as hh.mm.ss separators, whenever the digit is shown.
- Arbitration FSM has two states:
  - IDLE: `grant` = 0 and all slots are blank (`seg_com` still scans, `seg_data` = 00).
  - OWN: `grant` is one-hot.
- Next-owner rule, evaluated every cycle and applied to `grant` only on `frame_end`:
  - IDLE: go to the highest-priority asserted `req`. If none, stay in IDLE.
  - OWN, owner's `req` dropped: go to the highest remaining `req`, or to IDLE if none.
  - OWN, owner still requesting, higher-priority `req` asserted and hold == 0: preempt to that requester.
  - OWN, otherwise: keep the current owner. Equal or lower priority never preempts.
- `hold` counter:
  - Loads HOLD-1 on any `frame_end` that changes `grant` to a non-zero value.
  - Otherwise decrements each cycle, saturating at 0.
  - Clears to 0 when entering IDLE.
- Blink phase `bph`:
  - Free-running counter toggles `bph` every BLINK_HALF cycles. `bph` = 1 means on.
  - If the owner's `blink` bit = 1 and `bph` = 0, slots 0..5 output `seg_data` = 00. `seg_com` is unaffected.
- `digitsN` is sampled live each cycle; no snapshot is taken. Sources must hold their image stable or accept a mid-frame update.

## Timing
- Reset values: div=0, slot=0, grant=000, state IDLE, hold=0, bph=1, blink counter=0, seg_com=FF, seg_data=00.
- `seg_com` and `seg_data` are registered. They reflect the `slot`, `grant` and `digits` values of the previous cycle (1-cycle latency).
- `grant` change latency is from `req` change to the next `frame_end`, plus 1 cycle register. Worst case is 8·SCAN_DIV cycles.
- The first cycle of a new owner's display is always slot 0. No frame mixes two sources.
- Simultaneous drop of the owner and rise of another requester in the same frame: the new owner is taken at that `frame_end`. Hold does not apply.
- Preempt eligibility is checked at `frame_end` only. A higher request that rises and falls entirely within one frame is ignored.
- `rst` asserted mid-frame: all state returns to reset values on the next edge, and the display goes dark on the following cycle.
- The outputs never assert two `seg_com` bits low at once.

## Test plan
- Reset, then `req`=000 for 20 cycles → `grant`=000. `seg_com` cycles 7F, BF, DF, EF, F7, FB, FF, FF. `seg_data`=00 throughout.
- SCAN_DIV=1, `req`=001, `digits0`=0x123456 → at the first `frame_end` `grant`=001. The next frame shows `seg_data` 60, DB (2 with dp), F2, 67 (4 with dp), B6, BE.
- HOLD=16, owner 001. At cycle 3 of ownership assert `req`=101 → `grant` stays 001 until the first `frame_end` with hold == 0 (cycle 16), then becomes 100.
- Owner 100, drop `req[2]` with `req`=011 → at the next `frame_end` `grant`=010, with no hold wait. Then drop all requests → `grant`=000 at the following `frame_end`.
- BLINK_HALF=8, owner 010, `blink`=010 → `seg_data` is 00 in slots 0..5 for 8 cycles, then shown for 8 cycles, repeating. With `blink`=000 the digits are always shown.
- `digits1` nibble = 0xA → that slot shows 00. Assert `rst` for 1 cycle mid-frame → next cycle `seg_com`=FF, `seg_data`=00, `grant`=000.

Source files
------------

// File: rtl/seg_disp_arbiter.sv
// rtl/seg_disp_arbiter.sv - fixed-priority owner arbitration and 8-slot scan of one shared 7-segment display
module seg_disp_arbiter #(
  parameter int SCAN_DIV   = 1,
  parameter int HOLD       = 1000,
  parameter int BLINK_HALF = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic [23:0] digits0,
  input  logic [23:0] digits1,
  input  logic [23:0] digits2,
  input  logic [2:0]  blink,
  output logic [2:0]  grant,
  output logic [7:0]  seg_com,
  output logic [7:0]  seg_data
);

  typedef enum logic {IDLE, OWN} state_t;

  state_t      state, state_nxt;
  logic [31:0] div, hold, bcnt;
  logic [2:0]  slot, grant_nxt, top_req;
  logic        bph, tick, frame_end;
  logic [23:0] own_digits;
  logic [3:0]  nib;
  logic [7:0]  seg_dec, com_nxt, data_nxt;

  assign tick      = (div == 32'(SCAN_DIV - 1));
  assign frame_end = tick && (slot == 3'd7);
  assign top_req   = req[2] ? 3'b100 : req[1] ? 3'b010 : req[0] ? 3'b001 : 3'b000;

  always_ff @(posedge clk) begin
    if (rst) begin
      div  <= '0;
      slot <= '0;
      bcnt <= '0;
      bph  <= 1'b1;
    end else begin
      div <= tick ? '0 : div + 32'd1;
      if (tick) slot <= slot + 3'd1;
      if (bcnt == 32'(BLINK_HALF - 1)) begin
        bcnt <= '0;
        bph  <= ~bph;
      end else begin
        bcnt <= bcnt + 32'd1;
      end
    end
  end

  // Owner changes only at frame boundaries so a frame never mixes two sources.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      hold  <= '0;
    end else begin
      if (frame_end) begin
        state <= state_nxt;
        grant <= grant_nxt;
      end
      if (frame_end && grant_nxt != grant && grant_nxt != 3'b000)
        hold <= 32'(HOLD - 1);
      else if (frame_end && state_nxt == IDLE)
        hold <= '0;
      else if (hold != 32'd0)
        hold <= hold - 32'd1;
    end
  end

  always_comb begin
    grant_nxt = grant;
    case (state)
      IDLE: grant_nxt = top_req;
      OWN: begin
        if ((req & grant) == 3'b000)
          grant_nxt = top_req;
        else if (top_req != grant && hold == 32'd0)
          grant_nxt = top_req;
      end
    endcase
    state_nxt = (grant_nxt == 3'b000) ? IDLE : OWN;
  end

  always_comb begin
    own_digits = 24'h0;
    if (grant[2])      own_digits = digits2;
    else if (grant[1]) own_digits = digits1;
    else if (grant[0]) own_digits = digits0;

    com_nxt = 8'hFF;
    nib     = 4'hF;
    case (slot)
      3'd0: begin com_nxt = 8'h7F; nib = own_digits[23:20]; end
      3'd1: begin com_nxt = 8'hBF; nib = own_digits[19:16]; end
      3'd2: begin com_nxt = 8'hDF; nib = own_digits[15:12]; end
      3'd3: begin com_nxt = 8'hEF; nib = own_digits[11:8];  end
      3'd4: begin com_nxt = 8'hF7; nib = own_digits[7:4];   end
      3'd5: begin com_nxt = 8'hFB; nib = own_digits[3:0];   end
      default: ;
    endcase

    case (nib)
      4'd0: seg_dec = 8'hFC;
      4'd1: seg_dec = 8'h60;
      4'd2: seg_dec = 8'hDA;
      4'd3: seg_dec = 8'hF2;
      4'd4: seg_dec = 8'h66;
      4'd5: seg_dec = 8'hB6;
      4'd6: seg_dec = 8'hBE;
      4'd7: seg_dec = 8'hE0;
      4'd8: seg_dec = 8'hFE;
      4'd9: seg_dec = 8'hF6;
      default: seg_dec = 8'h00;
    endcase

    data_nxt = seg_dec;
    // Separator dots after hours and minutes, only on a real digit.
    if ((slot == 3'd1 || slot == 3'd3) && nib <= 4'd9) data_nxt[0] = 1'b1;
    if (state == IDLE || ((blink & grant) != 3'b000 && !bph)) data_nxt = 8'h00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_com  <= 8'hFF;
      seg_data <= 8'h00;
    end else begin
      seg_com  <= com_nxt;
      seg_data <= data_nxt;
    end
  end

endmodule

// File: tb/tb_seg_disp_arbiter.sv
// tb/tb_seg_disp_arbiter.sv - self-checking bench for seg_disp_arbiter
module tb_seg_disp_arbiter;
  localparam int SCAN_DIV   = 1;
  localparam int HOLD       = 16;
  localparam int BLINK_HALF = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  req = 3'b000;
  logic [2:0]  blink = 3'b000;
  logic [23:0] digits0 = 24'h0, digits1 = 24'h0, digits2 = 24'h0;
  logic [2:0]  grant;
  logic [7:0]  seg_com, seg_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seg_disp_arbiter #(.SCAN_DIV(SCAN_DIV), .HOLD(HOLD), .BLINK_HALF(BLINK_HALF)) dut (
    .clk(clk), .rst(rst), .req(req),
    .digits0(digits0), .digits1(digits1), .digits2(digits2),
    .blink(blink), .grant(grant), .seg_com(seg_com), .seg_data(seg_data)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: t counts cycles since reset, age counts cycles of current ownership.
  logic [7:0]  seg_tab [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                                 8'hFE, 8'hF6, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  int          t = 0, age = 0, m_slot;
  logic [2:0]  m_grant = 3'b000, m_nxt;
  logic [7:0]  m_com = 8'hFF, m_data = 8'h00;
  logic [23:0] m_img;
  logic [3:0]  m_nib;
  bit          model_valid = 1'b0;

  function automatic logic [2:0] top(input logic [2:0] r);
    if (r[2]) return 3'b100;
    if (r[1]) return 3'b010;
    if (r[0]) return 3'b001;
    return 3'b000;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      t = 0; age = 0; m_grant = 3'b000; m_com = 8'hFF; m_data = 8'h00;
      model_valid = 1'b1;
    end else begin
      m_slot = (t / SCAN_DIV) % 8;
      m_img  = (m_grant == 3'b100) ? digits2 : (m_grant == 3'b010) ? digits1 :
               (m_grant == 3'b001) ? digits0 : 24'h0;
      m_com  = (m_slot < 6) ? (8'hFF ^ (8'h80 >> m_slot)) : 8'hFF;
      m_data = 8'h00;
      if (m_grant != 3'b000 && m_slot < 6 &&
          !(((blink & m_grant) != 3'b000) && ((t / BLINK_HALF) % 2 == 1))) begin
        m_nib  = m_img[4*(5-m_slot) +: 4];
        m_data = seg_tab[m_nib];
        if ((m_slot == 1 || m_slot == 3) && m_nib <= 4'd9) m_data[0] = 1'b1;
      end
      if (t % (8*SCAN_DIV) == 8*SCAN_DIV - 1) begin
        if (m_grant == 3'b000 || (req & m_grant) == 3'b000)
          m_nxt = top(req);
        else if (top(req) != m_grant && age >= HOLD - 1)
          m_nxt = top(req);
        else
          m_nxt = m_grant;
        if (m_nxt != m_grant && m_nxt != 3'b000) age = 0;
        else age++;
        m_grant = m_nxt;
      end else begin
        age++;
      end
      t++;
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      chk("grant",    32'(grant),    32'(m_grant));
      chk("seg_com",  32'(seg_com),  32'(m_com));
      chk("seg_data", 32'(seg_data), 32'(m_data));
      chk("one_digit_low", 32'($countones(~seg_com) <= 1), 32'd1);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_grant(input logic [2:0] g, input int lim, output int steps);
    steps = 0;
    while (grant !== g && steps < lim) begin
      @(negedge clk);
      steps++;
    end
    chk("wait_grant", 32'(grant), 32'(g));
  endtask

  logic [7:0] scan_exp  [8] = '{8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFF, 8'hFF};
  logic [7:0] frame_exp [6] = '{8'h60, 8'hDB, 8'hF2, 8'h67, 8'hB6, 8'hBE};
  logic [7:0] blink_exp [6] = '{8'h00, 8'h61, 8'hDA, 8'hF3, 8'h66, 8'hB6};

  initial begin
    int s;
    digits2 = 24'h987654;
    rst = 1'b1;
    step(2);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_com",   32'(seg_com), 32'hFF);
    chk("rst_data",  32'(seg_data), 32'h00);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      step(1);
      chk("idle_scan", 32'(seg_com), 32'(scan_exp[i]));
      chk("idle_data", 32'(seg_data), 32'h00);
    end
    step(12);
    chk("idle_grant", 32'(grant), 32'd0);

    req = 3'b001; digits0 = 24'h123456;
    wait_grant(3'b001, 16, s);
    chk("first_grant_latency", 32'(s), 32'd4);
    for (int i = 0; i < 6; i++) begin
      step(1);
      chk("clock_frame", 32'(seg_data), 32'(frame_exp[i]));
      if (i == 2) req = 3'b101;
    end
    wait_grant(3'b100, 40, s);
    chk("preempt_cycle", 32'(s + 6), 32'd16);

    digits1 = 24'hA12345; blink = 3'b010; req = 3'b011;
    wait_grant(3'b010, 16, s);
    chk("drop_latency", 32'(s), 32'd8);
    for (int i = 0; i < 6; i++) begin
      step(1);
      chk("blink_on", 32'(seg_data), 32'(blink_exp[i]));
    end
    step(2);
    for (int i = 0; i < 6; i++) begin
      step(1);
      chk("blink_off", 32'(seg_data), 32'h00);
    end
    step(10);
    blink = 3'b000;
    for (int i = 0; i < 6; i++) begin
      step(1);
      chk("no_blink", 32'(seg_data), 32'(blink_exp[i]));
    end

    req = 3'b000;
    wait_grant(3'b000, 16, s);
    chk("idle_latency", 32'(s), 32'd2);

    req = 3'b001;
    wait_grant(3'b001, 16, s);
    step(18);
    req = 3'b101;
    step(3);
    req = 3'b001;
    step(8);
    chk("pulse_ignored", 32'(grant), 32'b001);

    rst = 1'b1;
    step(1);
    chk("midrst_grant", 32'(grant), 32'd0);
    chk("midrst_com",   32'(seg_com), 32'hFF);
    chk("midrst_data",  32'(seg_data), 32'h00);
    rst = 1'b0;
    step(12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
